// File: rtl/instruction_encoder_loader_pkg.sv
// Shared opcode/funct encodings, field positions and loader FSM states.
// The decode stage imports this same package so both sides agree on legality.
package instr_pkg;

  // Opcodes
  localparam logic [3:0] OP_R     = 4'b0000;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_BNE   = 4'b0101;
  localparam logic [3:0] OP_BLT   = 4'b0110;
  localparam logic [3:0] OP_LOAD  = 4'b1000;
  localparam logic [3:0] OP_STORE = 4'b1011;
  localparam logic [3:0] OP_JUMP  = 4'b1100;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  // R/shift funct codes
  localparam logic [3:0] F_ADD = 4'b1111;
  localparam logic [3:0] F_SUB = 4'b1110;
  localparam logic [3:0] F_AND = 4'b1101;
  localparam logic [3:0] F_OR  = 4'b1100;
  localparam logic [3:0] F_SLL = 4'b0001;
  localparam logic [3:0] F_SRL = 4'b0010;
  localparam logic [3:0] F_SRA = 4'b1010;
  localparam logic [3:0] F_ROR = 4'b1011;
  localparam logic [3:0] F_MUL = 4'b1000;
  localparam logic [3:0] F_DIV = 4'b1001;

  // Field bit positions inside the 16-bit word
  localparam int OP_LSB = 12;
  localparam int A_LSB  = 8;
  localparam int B_LSB  = 4;
  localparam int IMM4_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic funct_legal(input logic [3:0] f);
    case (f)
      F_ADD, F_SUB, F_AND, F_OR, F_SLL,
      F_SRL, F_SRA, F_ROR, F_MUL, F_DIV: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instruction_encoder_loader_packer.sv
// Combinational packer: {op, funct, fields} -> {word, illegal}.
// Optional INSTR_IMM_CHECK_EN: reject requests carrying IMM bits beyond
// the field the opcode uses; otherwise those bits are truncated.
module instr_field_packer
  import instr_pkg::*;
#(
  parameter int OPSIZE  = 4,
  parameter int INSTR_W = 16
) (
  input  logic [OPSIZE-1:0]  op,
  input  logic [OPSIZE-1:0]  funct,
  input  logic [3:0]         field_a,
  input  logic [3:0]         field_b,
  input  logic [11:0]        imm,
  output logic [INSTR_W-1:0] word,
  output logic               illegal
);

  // Opcode-driven field packing and legality decode
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op)
      OP_R: begin
        word    = {op, field_a, field_b, funct};
        illegal = !funct_legal(funct);
`ifdef INSTR_IMM_CHECK_EN
        if (|imm) illegal = 1'b1;
`endif
      end
      OP_LOAD, OP_STORE, OP_BEQ, OP_BNE, OP_BLT: begin
        word = {op, field_a, field_b, imm[IMM4_W-1:0]};
`ifdef INSTR_IMM_CHECK_EN
        if (|imm[11:IMM4_W]) illegal = 1'b1;
`endif
      end
      OP_JUMP: word = {op, imm};
      OP_HALT: begin
        word = {op, 12'h000};
`ifdef INSTR_IMM_CHECK_EN
        if (|imm) illegal = 1'b1;
`endif
      end
      default: begin
        word    = {op, 12'h000};
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instruction_encoder_loader.sv
// Instruction encoder/loader: packs symbolic requests into instruction
// words and writes them sequentially into instruction memory until a halt
// is written or the last address is used.
// Optional feature macro: INSTR_IMM_CHECK_EN (excess IMM bits are illegal).
module instruction_encoder_loader
  import instr_pkg::*;
#(
  parameter int OPSIZE  = 4,
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [OPSIZE-1:0]  op_code,
  input  logic [OPSIZE-1:0]  func_code,
  input  logic [3:0]         field_a,
  input  logic [3:0]         field_b,
  input  logic [11:0]        imm,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  input  logic               imem_ready,
  output logic               wrong_op_code,
  output logic               done,
  output logic               overflow
);

  state_t             state, state_nxt;
  logic               started;
  logic               halt_q;
  logic [INSTR_W-1:0] word;
  logic               illegal;
  logic               accept;
  logic               wr_fire;
  logic               last_addr;

  instr_field_packer #(.OPSIZE(OPSIZE), .INSTR_W(INSTR_W)) u_packer (
    .op      (op_code),
    .funct   (func_code),
    .field_a (field_a),
    .field_b (field_b),
    .imm     (imm),
    .word    (word),
    .illegal (illegal)
  );

  assign accept    = req_valid & req_ready;
  assign wr_fire   = imem_we & imem_ready;
  assign last_addr = &imem_addr;

  // State register; async reset abandons any write immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake/strobe outputs; clear has priority everywhere
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    imem_we   = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = started & !clear;
        if (accept && !illegal) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        imem_we = 1'b1;
        if (imem_ready) state_nxt = (halt_q || last_addr) ? ST_DONE : ST_IDLE;
      end
      ST_DONE: done = 1'b1;
      default: state_nxt = ST_IDLE;
    endcase
    if (clear) state_nxt = ST_IDLE;
  end

  // Word capture, address counter, reject pulse and overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started       <= 1'b0;
      halt_q        <= 1'b0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      wrong_op_code <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      started       <= 1'b1;
      wrong_op_code <= accept & illegal;
      if (clear) begin
        imem_addr <= '0;
        overflow  <= 1'b0;
      end else if (accept && !illegal) begin
        imem_wdata <= word;
        halt_q     <= (op_code == OP_HALT);
      end else if (wr_fire && !halt_q) begin
        // The address saturates at the top; the final write flags overflow
        if (last_addr) overflow  <= 1'b1;
        else           imem_addr <= imem_addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Self-checking bench for instruction_encoder_loader: directed scenarios plus
// randomized requests against a behavioural model of encoding and legality.
module tb_instruction_encoder_loader;

  localparam int AW   = 4;
  localparam int MAXA = (1 << AW) - 1;

  logic          clk, rst_n, clear, req_valid, req_ready;
  logic [3:0]    op_code, func_code, field_a, field_b;
  logic [11:0]   imm;
  logic          imem_we, imem_ready, wrong_op_code, done, overflow;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wdata;

  int checks = 0, failures = 0;
  int exp_addr = 0;
  bit exp_done = 0, exp_ovf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  instruction_encoder_loader #(.OPSIZE(4), .INSTR_W(16), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready),
    .op_code(op_code), .func_code(func_code),
    .field_a(field_a), .field_b(field_b), .imm(imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_ready(imem_ready), .wrong_op_code(wrong_op_code),
    .done(done), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_mem_br(input logic [3:0] op);
    return (op == 4'h8 || op == 4'hB || op == 4'h4 || op == 4'h5 || op == 4'h6);
  endfunction

  function automatic bit model_legal(input logic [3:0] op, input logic [3:0] f,
                                     input logic [11:0] im);
    bit ok;
    if (op == 4'h0)
      ok = (f == 4'hF || f == 4'hE || f == 4'hD || f == 4'hC || f == 4'h1 ||
            f == 4'h2 || f == 4'hA || f == 4'hB || f == 4'h8 || f == 4'h9);
    else
      ok = is_mem_br(op) || op == 4'hC || op == 4'hF;
`ifdef INSTR_IMM_CHECK_EN
    if ((op == 4'h0 || op == 4'hF) && im != 12'h0) ok = 0;
    if (is_mem_br(op) && int'(im) > 15) ok = 0;
`endif
    return ok;
  endfunction

  function automatic int model_word(input logic [3:0] op, input logic [3:0] f,
                                    input logic [3:0] a, input logic [3:0] b,
                                    input logic [11:0] im);
    int w;
    w = int'(op) * 4096;
    if (op == 4'h0)         w += int'(a) * 256 + int'(b) * 16 + int'(f);
    else if (is_mem_br(op)) w += int'(a) * 256 + int'(b) * 16 + (int'(im) % 16);
    else if (op == 4'hC)    w += int'(im);
    return w;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 20) begin cyc(); n++; end
    chk("ready_wait", req_ready, 1'b1);
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] f, input logic [3:0] a,
                      input logic [3:0] b, input logic [11:0] im, input int stall);
    bit legal;
    int w;
    wait_ready();
    legal = model_legal(op, f, im);
    w     = model_word(op, f, a, b, im);
    op_code = op; func_code = f; field_a = a; field_b = b; imm = im;
    req_valid = 1'b1;
    cyc();
    req_valid = 1'b0;
    if (legal) begin
      chk("we_next", imem_we, 1'b1);
      chk("addr", imem_addr, exp_addr);
      chk("wdata", imem_wdata, w);
      chk("ready_low_wr", req_ready, 1'b0);
      chk("no_wrong", wrong_op_code, 1'b0);
      for (int i = 0; i < stall; i++) begin
        cyc();
        chk("stall_we", imem_we, 1'b1);
        chk("stall_wdata", imem_wdata, w);
        chk("stall_ready", req_ready, 1'b0);
      end
      imem_ready = 1'b1;
      cyc();
      imem_ready = 1'b0;
      if (op == 4'hF || exp_addr == MAXA) begin
        exp_done = 1;
        if (op != 4'hF) exp_ovf = 1;
      end else exp_addr++;
      chk("we_drop", imem_we, 1'b0);
      chk("done", done, exp_done);
      chk("overflow", overflow, exp_ovf);
      chk("addr_after", imem_addr, exp_addr);
      chk("ready_after", req_ready, !exp_done);
    end else begin
      chk("wrong_pulse", wrong_op_code, 1'b1);
      chk("wrong_no_we", imem_we, 1'b0);
      chk("wrong_addr", imem_addr, exp_addr);
      chk("wrong_ready", req_ready, 1'b1);
      cyc();
      chk("wrong_once", wrong_op_code, 1'b0);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    #1;
    chk("clear_ready", req_ready, 1'b0);
    cyc();
    clear = 1'b0;
    #1;
    exp_addr = 0; exp_done = 0; exp_ovf = 0;
    chk("clr_addr", imem_addr, 0);
    chk("clr_done", done, 1'b0);
    chk("clr_ovf", overflow, 1'b0);
    chk("clr_we", imem_we, 1'b0);
    chk("clr_ready", req_ready, 1'b1);
  endtask

  initial begin
    logic [3:0]  rop, rf;
    logic [11:0] rim;
    rst_n = 1'b0; clear = 1'b0; req_valid = 1'b0; imem_ready = 1'b0;
    op_code = '0; func_code = '0; field_a = '0; field_b = '0; imm = '0;
    cyc(); cyc();
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_we", imem_we, 1'b0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_wrong", wrong_op_code, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready0", req_ready, 1'b0);
    cyc();
    chk("rel_ready1", req_ready, 1'b1);

    // Add, jump, halt
    send(4'h0, 4'hF, 4'h3, 4'h5, 12'h000, 0);
    send(4'hC, 4'h0, 4'h0, 4'h0, 12'hABC, 0);
    send(4'hF, 4'h0, 4'h0, 4'h0, 12'h000, 0);
    cyc(); cyc();
    chk("halt_done_hold", done, 1'b1);
    chk("halt_ready_hold", req_ready, 1'b0);
    chk("halt_addr_hold", imem_addr, 2);
    do_clear();

    // Illegal funct and opcode, stalled write, load with wide IMM
    send(4'h0, 4'h3, 4'h1, 4'h2, 12'h000, 0);
    send(4'h3, 4'h0, 4'h1, 4'h2, 12'h000, 0);
    send(4'h0, 4'hF, 4'h1, 4'h2, 12'h000, 5);
    send(4'h8, 4'h0, 4'h1, 4'h2, 12'h010, 0);

    // Clear while the memory stalls: write abandoned
    wait_ready();
    op_code = 4'h0; func_code = 4'hE; field_a = 4'h7; field_b = 4'h1; imm = '0;
    req_valid = 1'b1;
    cyc();
    req_valid = 1'b0;
    chk("cw_we", imem_we, 1'b1);
    cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    #1;
    exp_addr = 0; exp_done = 0; exp_ovf = 0;
    chk("cw_we_off", imem_we, 1'b0);
    chk("cw_addr", imem_addr, 0);
    chk("cw_ready", req_ready, 1'b1);

    // Async reset during a write
    send(4'h0, 4'hD, 4'h2, 4'h2, 12'h000, 0);
    wait_ready();
    op_code = 4'h0; func_code = 4'hC; imm = '0;
    req_valid = 1'b1;
    cyc();
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_we", imem_we, 1'b0);
    chk("arst_addr", imem_addr, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    exp_addr = 0; exp_done = 0; exp_ovf = 0;

    // Fill memory without a halt
    for (int i = 0; i <= MAXA; i++)
      send(4'h0, 4'h1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 12'h000, 0);
    chk("full_ovf", overflow, 1'b1);
    chk("full_done", done, 1'b1);
    chk("full_addr", imem_addr, MAXA);
    do_clear();

    // Randomized requests
    for (int i = 0; i < 120; i++) begin
      if (exp_done) do_clear();
      rop = 4'($urandom_range(0, 15));
      rf  = 4'($urandom_range(0, 15));
      rim = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 15)) : 12'($urandom);
      send(rop, rf, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), rim,
           int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
